// File: rtl/ysyx_210247_cache_axi_bridge.sv
// ysyx_210247_cache_axi_bridge
// Bridges the data cache's single-outstanding 128-bit line request onto a
// 64-bit AXI4 bus. Line fills become 2-beat INCR reads and dirty-line
// writebacks become 2-beat INCR writes. Each request gets one
// mem_resp_valid pulse.
// Optional feature: define YSYX_210247_BRIDGE_ERR_EN to add a sticky bus
// error flag (bus_err) and the line address of the first error (bus_err_addr).
module ysyx_210247_cache_axi_bridge #(
    parameter int         LINE_W = 128,
    parameter int         AXI_DW = 64,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_req_wen,
    input  logic              mem_req_valid,
    output logic              mem_resp_valid,
    output logic [LINE_W-1:0] mem_resp_data,
    output logic              axi_aw_valid,
    input  logic              axi_aw_ready,
    output logic [31:0]       axi_aw_addr,
    output logic [3:0]        axi_aw_id,
    output logic [7:0]        axi_aw_len,
    output logic [2:0]        axi_aw_size,
    output logic [1:0]        axi_aw_burst,
    output logic              axi_w_valid,
    input  logic              axi_w_ready,
    output logic [AXI_DW-1:0] axi_w_data,
    output logic [7:0]        axi_w_strb,
    output logic              axi_w_last,
    input  logic              axi_b_valid,
    output logic              axi_b_ready,
    input  logic [1:0]        axi_b_resp,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    output logic [31:0]       axi_ar_addr,
    output logic [3:0]        axi_ar_id,
    output logic [7:0]        axi_ar_len,
    output logic [2:0]        axi_ar_size,
    output logic [1:0]        axi_ar_burst,
    input  logic              axi_r_valid,
    output logic              axi_r_ready,
    input  logic [AXI_DW-1:0] axi_r_data,
    input  logic [1:0]        axi_r_resp,
    input  logic              axi_r_last
`ifdef YSYX_210247_BRIDGE_ERR_EN
    ,
    output logic              bus_err,
    output logic [31:0]       bus_err_addr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP, S_HOLD
    } state_t;

    state_t              state_r;
    logic [31:0]         addr_r;
    logic [LINE_W-1:0]   data_r;
    logic                wen_r;
    logic                beat_r;
    logic                unused_s;

    // Fixed burst shape: two 8-byte beats, incrementing, constant ID.
    assign axi_aw_id    = AXI_ID;
    assign axi_aw_len   = 8'd1;
    assign axi_aw_size  = 3'd3;
    assign axi_aw_burst = 2'b01;
    assign axi_ar_id    = AXI_ID;
    assign axi_ar_len   = 8'd1;
    assign axi_ar_size  = 3'd3;
    assign axi_ar_burst = 2'b01;
    assign axi_w_strb   = 8'hff;
    // Addresses come straight from the frozen line address register.
    assign axi_aw_addr  = addr_r;
    assign axi_ar_addr  = addr_r;

    // rlast is not used (the beat counter terminates the burst); the low
    // address bits are forced to zero; wen only steers the IDLE decision.
    assign unused_s = ^{mem_req_addr[3:0], axi_r_resp, axi_b_resp, axi_r_last, wen_r};

    // Transfer sequencer: all AXI valids/readies and the response pulse are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_IDLE;
            addr_r         <= 32'd0;
            data_r         <= {LINE_W{1'b0}};
            wen_r          <= 1'b0;
            beat_r         <= 1'b0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= {LINE_W{1'b0}};
            axi_aw_valid   <= 1'b0;
            axi_w_valid    <= 1'b0;
            axi_w_data     <= {AXI_DW{1'b0}};
            axi_w_last     <= 1'b0;
            axi_b_ready    <= 1'b0;
            axi_ar_valid   <= 1'b0;
            axi_r_ready    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (mem_req_valid) begin
                        addr_r <= {mem_req_addr[31:4], 4'h0};
                        data_r <= mem_req_data;
                        wen_r  <= mem_req_wen;
                        if (mem_req_wen) begin
                            axi_aw_valid <= 1'b1;
                            state_r      <= S_AW;
                        end else begin
                            axi_ar_valid <= 1'b1;
                            state_r      <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (axi_ar_ready) begin
                        axi_ar_valid <= 1'b0;
                        axi_r_ready  <= 1'b1;
                        beat_r       <= 1'b0;
                        state_r      <= S_R;
                    end
                end
                S_R: begin
                    if (axi_r_valid) begin
                        if (!beat_r) begin
                            mem_resp_data[AXI_DW-1:0] <= axi_r_data;
                            beat_r                    <= 1'b1;
                        end else begin
                            mem_resp_data[LINE_W-1:AXI_DW] <= axi_r_data;
                            axi_r_ready                    <= 1'b0;
                            mem_resp_valid                 <= 1'b1;
                            state_r                        <= S_RESP;
                        end
                    end
                end
                S_AW: begin
                    if (axi_aw_ready) begin
                        axi_aw_valid <= 1'b0;
                        axi_w_valid  <= 1'b1;
                        axi_w_data   <= data_r[AXI_DW-1:0];
                        axi_w_last   <= 1'b0;
                        beat_r       <= 1'b0;
                        state_r      <= S_W;
                    end
                end
                S_W: begin
                    if (axi_w_ready) begin
                        if (!beat_r) begin
                            axi_w_data <= data_r[LINE_W-1:AXI_DW];
                            axi_w_last <= 1'b1;
                            beat_r     <= 1'b1;
                        end else begin
                            axi_w_valid <= 1'b0;
                            axi_w_last  <= 1'b0;
                            axi_b_ready <= 1'b1;
                            state_r     <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (axi_b_valid) begin
                        axi_b_ready    <= 1'b0;
                        mem_resp_valid <= 1'b1;
                        state_r        <= S_RESP;
                    end
                end
                S_RESP: begin
                    mem_resp_valid <= 1'b0;
                    state_r        <= S_HOLD;
                end
                S_HOLD: begin
                    // A request left high after its response is not re-issued.
                    if (!mem_req_valid) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef YSYX_210247_BRIDGE_ERR_EN
    // Sticky error flag; the address of the first failing line is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err      <= 1'b0;
            bus_err_addr <= 32'd0;
        end else if (!bus_err &&
                     (((state_r == S_R) && axi_r_valid && axi_r_resp[1]) ||
                      ((state_r == S_B) && axi_b_valid && axi_b_resp[1]))) begin
            bus_err      <= 1'b1;
            bus_err_addr <= addr_r;
        end else begin
            bus_err      <= bus_err;
            bus_err_addr <= bus_err_addr;
        end
    end
`endif

endmodule
